mc_control: RTL and testbench

MC_CONTROL -- requirements
Module: mc_control

---
 rtl/mc_pkg.sv | 78 +++++++
 rtl/mc_decode.sv | 110 +++++++++++
 rtl/mc_control.sv | 227 ++++++++++++++++++++++
 tb/tb_mc_control.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/mc_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mc_pkg
//  Description : Shared constants for the multicycle control path and the ALU:
//                FSM state codes, MIPS opcode/funct codes, ALU opcode
//                encoding and the instruction-class type used by the decoder.
//  Revision    : 1.0  initial release
// ============================================================================
package mc_pkg;

    // FSM state codes (codes 5..7 are unused and recover to FETCH)
    localparam logic [2:0] ST_FETCH  = 3'd0;
    localparam logic [2:0] ST_DECODE = 3'd1;
    localparam logic [2:0] ST_EXEC   = 3'd2;
    localparam logic [2:0] ST_MEM    = 3'd3;
    localparam logic [2:0] ST_WB     = 3'd4;

    // Primary opcodes, instr[31:26]
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    // R-type function codes, instr[5:0]
    localparam logic [5:0] FN_SLL  = 6'h00;
    localparam logic [5:0] FN_SRL  = 6'h02;
    localparam logic [5:0] FN_SRA  = 6'h03;
    localparam logic [5:0] FN_JR   = 6'h08;
    localparam logic [5:0] FN_ADD  = 6'h20;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUB  = 6'h22;
    localparam logic [5:0] FN_SUBU = 6'h23;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_NOR  = 6'h27;
    localparam logic [5:0] FN_SLT  = 6'h2A;

    // ALU opcode encoding shared with the ALU
    localparam logic [3:0] ALU_NOP  = 4'h0;
    localparam logic [3:0] ALU_ADD  = 4'h1;
    localparam logic [3:0] ALU_ADDU = 4'h2;
    localparam logic [3:0] ALU_SUB  = 4'h3;
    localparam logic [3:0] ALU_SUBU = 4'h4;
    localparam logic [3:0] ALU_AND  = 4'h5;
    localparam logic [3:0] ALU_OR   = 4'h6;
    localparam logic [3:0] ALU_NOR  = 4'h7;
    localparam logic [3:0] ALU_SLT  = 4'h8;
    localparam logic [3:0] ALU_SLL  = 4'h9;
    localparam logic [3:0] ALU_SRL  = 4'hA;
    localparam logic [3:0] ALU_SRA  = 4'hB;
    localparam logic [3:0] ALU_JR   = 4'hC;
    localparam logic [3:0] ALU_BNE  = 4'hD;

    // Instruction class: selects the FSM path after DECODE
    typedef enum logic [2:0] {
        CLS_RALU    = 3'd0,   // R-type ALU op, writes rd
        CLS_IALU    = 3'd1,   // immediate ALU op, writes rt
        CLS_LW      = 3'd2,
        CLS_SW      = 3'd3,
        CLS_BRANCH  = 3'd4,   // beq / bne
        CLS_JR      = 3'd5,
        CLS_J       = 3'd6,
        CLS_ILLEGAL = 3'd7
    } instr_class_e;

    // True for the classes that visit the MEM state
    function automatic logic is_mem_class(input instr_class_e cls);
        return (cls == CLS_LW) || (cls == CLS_SW);
    endfunction

endpackage
`default_nettype wire

// File: rtl/mc_decode.sv
`default_nettype none
// ============================================================================
//  Module      : mc_decode
//  Description : Purely combinational instruction decode for the multicycle
//                control path.
//  Ports       : i_opcode   - instr[31:26]
//                i_funct    - instr[5:0]
//                o_alu_op   - ALU opcode (ALU_NOP for undecodable instructions)
//                o_alu_src  - 1 = immediate operand
//                o_sign_ext - 1 = sign-extend imm16
//                o_cls      - instruction class
//                o_legal    - 1 when the instruction is decodable
//  Revision    : 1.0  initial release
// ============================================================================
module mc_decode
    import mc_pkg::*;
(
    input  logic [5:0]   i_opcode,
    input  logic [5:0]   i_funct,
    output logic [3:0]   o_alu_op,
    output logic         o_alu_src,
    output logic         o_sign_ext,
    output instr_class_e o_cls,
    output logic         o_legal
);

    always_comb begin
        o_alu_op   = ALU_NOP;
        o_alu_src  = 1'b0;
        o_sign_ext = 1'b1;
        o_cls      = CLS_ILLEGAL;

        case (i_opcode)
            OP_RTYPE: begin
                o_cls = CLS_RALU;
                case (i_funct)
                    FN_ADD:  o_alu_op = ALU_ADD;
                    FN_ADDU: o_alu_op = ALU_ADDU;
                    FN_SUB:  o_alu_op = ALU_SUB;
                    FN_SUBU: o_alu_op = ALU_SUBU;
                    FN_AND:  o_alu_op = ALU_AND;
                    FN_OR:   o_alu_op = ALU_OR;
                    FN_NOR:  o_alu_op = ALU_NOR;
                    FN_SLT:  o_alu_op = ALU_SLT;
                    FN_SLL:  o_alu_op = ALU_SLL;
                    FN_SRL:  o_alu_op = ALU_SRL;
                    FN_SRA:  o_alu_op = ALU_SRA;
                    FN_JR: begin
                        o_alu_op = ALU_JR;
                        o_cls    = CLS_JR;
                    end
                    default: o_cls = CLS_ILLEGAL;
                endcase
            end
            OP_J: o_cls = CLS_J;
            OP_BEQ: begin
                o_alu_op = ALU_SUB;
                o_cls    = CLS_BRANCH;
            end
            OP_BNE: begin
                // BNE opcode makes the ALU raise Zero on inequality
                o_alu_op = ALU_BNE;
                o_cls    = CLS_BRANCH;
            end
            OP_ADDI: begin
                o_alu_op  = ALU_ADD;
                o_alu_src = 1'b1;
                o_cls     = CLS_IALU;
            end
            OP_ADDIU: begin
                o_alu_op  = ALU_ADDU;
                o_alu_src = 1'b1;
                o_cls     = CLS_IALU;
            end
            OP_ANDI: begin
                o_alu_op   = ALU_AND;
                o_alu_src  = 1'b1;
                o_sign_ext = 1'b0;
                o_cls      = CLS_IALU;
            end
            OP_ORI: begin
                o_alu_op   = ALU_OR;
                o_alu_src  = 1'b1;
                o_sign_ext = 1'b0;
                o_cls      = CLS_IALU;
            end
            OP_LW: begin
                o_alu_op  = ALU_ADD;
                o_alu_src = 1'b1;
                o_cls     = CLS_LW;
            end
            OP_SW: begin
                o_alu_op  = ALU_ADD;
                o_alu_src = 1'b1;
                o_cls     = CLS_SW;
            end
            default: o_cls = CLS_ILLEGAL;
        endcase

        // An undecodable instruction never carries ALU controls
        if (o_cls == CLS_ILLEGAL) begin
            o_alu_op   = ALU_NOP;
            o_alu_src  = 1'b0;
            o_sign_ext = 1'b1;
        end
        o_legal = (o_cls != CLS_ILLEGAL);
    end

endmodule
`default_nettype wire

// File: rtl/mc_control.sv
`default_nettype none
// ============================================================================
//  Module      : mc_control
//  Description : Multicycle MIPS-subset control FSM
//                (FETCH -> DECODE -> EXEC -> MEM -> WB).
//  Parameters  : TRAP_ON_ILLEGAL - 1 = pulse illegal on an undecodable
//                                  instruction, 0 = silent no-op
//  Ports       : clk, rst (async, active-high)
//                opcode, funct   - instruction fields from the IR
//                zero            - ALU Zero flag
//                mem_ready       - memory access complete
//                alu_op, alu_src, sign_ext    - datapath ALU controls
//                pc_write, pc_src, ir_write   - PC / IR controls
//                reg_write, reg_dst, mem_to_reg - register-file controls
//                mem_req, mem_we              - memory controls
//                illegal         - one-cycle undecodable-instruction pulse
//                state           - current FSM state (debug)
//  Revision    : 1.0  initial release
// ============================================================================
module mc_control
    import mc_pkg::*;
#(
    parameter bit TRAP_ON_ILLEGAL = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       mem_ready,
    output logic [3:0] alu_op,
    output logic       alu_src,
    output logic       sign_ext,
    output logic       pc_write,
    output logic [1:0] pc_src,
    output logic       ir_write,
    output logic       reg_write,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       mem_req,
    output logic       mem_we,
    output logic       illegal,
    output logic [2:0] state
);

    // ------------------------------------------------------------------
    // Decode (only consulted while in DECODE; results latched there)
    // ------------------------------------------------------------------
    logic [3:0]   dec_alu_op;
    logic         dec_alu_src;
    logic         dec_sign_ext;
    instr_class_e dec_cls;
    logic         dec_legal;

    mc_decode u_decode (
        .i_opcode   (opcode),
        .i_funct    (funct),
        .o_alu_op   (dec_alu_op),
        .o_alu_src  (dec_alu_src),
        .o_sign_ext (dec_sign_ext),
        .o_cls      (dec_cls),
        .o_legal    (dec_legal)
    );

    // ------------------------------------------------------------------
    // State and latched decode results
    // ------------------------------------------------------------------
    logic [2:0]   state_q,    state_d;
    logic [3:0]   alu_op_q,   alu_op_d;
    logic         alu_src_q,  alu_src_d;
    logic         sign_ext_q, sign_ext_d;
    instr_class_e cls_q,      cls_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_FETCH;
            alu_op_q   <= ALU_NOP;
            alu_src_q  <= 1'b0;
            sign_ext_q <= 1'b1;
            cls_q      <= CLS_ILLEGAL;
        end else begin
            state_q    <= state_d;
            alu_op_q   <= alu_op_d;
            alu_src_q  <= alu_src_d;
            sign_ext_q <= sign_ext_d;
            cls_q      <= cls_d;
        end
    end

    // Capturing in DECODE keeps ALU controls stable through EXEC/MEM/WB
    // even if the IR fields move underneath.
    always_comb begin
        alu_op_d   = alu_op_q;
        alu_src_d  = alu_src_q;
        sign_ext_d = sign_ext_q;
        cls_d      = cls_q;
        if (state_q == ST_DECODE) begin
            alu_op_d   = dec_alu_op;
            alu_src_d  = dec_alu_src;
            sign_ext_d = dec_sign_ext;
            cls_d      = dec_cls;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = ST_FETCH;
        case (state_q)
            ST_FETCH:  state_d = mem_ready ? ST_DECODE : ST_FETCH;
            ST_DECODE: begin
                if (dec_cls == CLS_J || dec_cls == CLS_ILLEGAL) begin
                    state_d = ST_FETCH;
                end else begin
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                if (cls_q == CLS_BRANCH || cls_q == CLS_JR) begin
                    state_d = ST_FETCH;
                end else if (is_mem_class(cls_q)) begin
                    state_d = ST_MEM;
                end else begin
                    state_d = ST_WB;
                end
            end
            ST_MEM: begin
                if (!mem_ready) begin
                    state_d = ST_MEM;
                end else if (cls_q == CLS_LW) begin
                    state_d = ST_WB;
                end else begin
                    state_d = ST_FETCH;
                end
            end
            ST_WB:   state_d = ST_FETCH;
            default: state_d = ST_FETCH;
        endcase
    end

    // ------------------------------------------------------------------
    // Output logic
    // ------------------------------------------------------------------
    logic in_exec_phase;
    assign in_exec_phase = (state_q == ST_EXEC) || (state_q == ST_MEM) ||
                           (state_q == ST_WB);

    always_comb begin
        alu_op     = ALU_NOP;
        alu_src    = 1'b0;
        sign_ext   = 1'b1;
        pc_write   = 1'b0;
        pc_src     = 2'd0;
        ir_write   = 1'b0;
        reg_write  = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        illegal    = 1'b0;

        if (in_exec_phase) begin
            alu_op   = alu_op_q;
            alu_src  = alu_src_q;
            sign_ext = sign_ext_q;
        end

        case (state_q)
            ST_FETCH: begin
                mem_req = 1'b1;
                if (mem_ready) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    pc_src   = 2'd0;
                end
            end
            ST_DECODE: begin
                if (dec_cls == CLS_J) begin
                    pc_write = 1'b1;
                    pc_src   = 2'd2;
                end
                illegal = TRAP_ON_ILLEGAL && !dec_legal;
            end
            ST_EXEC: begin
                if (cls_q == CLS_BRANCH) begin
                    // beq and bne both branch on Zero (bne ALU op inverts it)
                    pc_write = zero;
                    pc_src   = 2'd1;
                end else if (cls_q == CLS_JR) begin
                    pc_write = 1'b1;
                    pc_src   = 2'd3;
                end
            end
            ST_MEM: begin
                mem_req = 1'b1;
                mem_we  = (cls_q == CLS_SW);
            end
            ST_WB: begin
                reg_write  = 1'b1;
                reg_dst    = (cls_q == CLS_RALU);
                mem_to_reg = (cls_q == CLS_LW);
            end
            default: ;
        endcase

        // Reset takes effect on the outputs without waiting for a clock edge
        if (rst) begin
            alu_op     = ALU_NOP;
            alu_src    = 1'b0;
            sign_ext   = 1'b1;
            pc_write   = 1'b0;
            pc_src     = 2'd0;
            ir_write   = 1'b0;
            reg_write  = 1'b0;
            reg_dst    = 1'b0;
            mem_to_reg = 1'b0;
            mem_req    = 1'b0;
            mem_we     = 1'b0;
            illegal    = 1'b0;
        end
    end

    assign state = state_q;

endmodule
`default_nettype wire

// File: tb/tb_mc_control.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mc_control
//  Description : Directed self-checking bench for mc_control. Every cycle the
//                full output bundle is compared against a hand-computed vector
//                {state, alu_op, alu_src, sign_ext, pc_write, pc_src, ir_write,
//                 reg_write, reg_dst, mem_to_reg, mem_req, mem_we, illegal}.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_mc_control;

    logic       clk;
    logic       rst;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       zero;
    logic       mem_ready;
    logic [3:0] alu_op;
    logic       alu_src;
    logic       sign_ext;
    logic       pc_write;
    logic [1:0] pc_src;
    logic       ir_write;
    logic       reg_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       mem_req;
    logic       mem_we;
    logic       illegal;
    logic [2:0] state;

    int checks = 0;
    int errors = 0;

    mc_control #(.TRAP_ON_ILLEGAL(1'b1)) dut (
        .clk        (clk),
        .rst        (rst),
        .opcode     (opcode),
        .funct      (funct),
        .zero       (zero),
        .mem_ready  (mem_ready),
        .alu_op     (alu_op),
        .alu_src    (alu_src),
        .sign_ext   (sign_ext),
        .pc_write   (pc_write),
        .pc_src     (pc_src),
        .ir_write   (ir_write),
        .reg_write  (reg_write),
        .reg_dst    (reg_dst),
        .mem_to_reg (mem_to_reg),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .illegal    (illegal),
        .state      (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [18:0] obs;
    assign obs = {state, alu_op, alu_src, sign_ext, pc_write, pc_src, ir_write,
                  reg_write, reg_dst, mem_to_reg, mem_req, mem_we, illegal};

    function automatic logic [18:0] ev(
        input int st, input int aop, input int asrc, input int sext,
        input int pcw, input int pcs, input int irw, input int rw,
        input int rd, input int m2r, input int mreq, input int mwe,
        input int ill);
        return {3'(st), 4'(aop), 1'(asrc), 1'(sext), 1'(pcw), 2'(pcs),
                1'(irw), 1'(rw), 1'(rd), 1'(m2r), 1'(mreq), 1'(mwe), 1'(ill)};
    endfunction

    task automatic chk(input string tag, input logic [18:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $display("FAIL %s observed=%05h expected=%05h", tag, obs, expv);
            $error("check %s", tag);
        end
    endtask

    // Advance one clock and settle just after the edge
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // FETCH with memory ready: load IR, PC+4, then step into DECODE
    task automatic fetch(input string tag, input logic [5:0] op, input logic [5:0] fn);
        opcode    = op;
        funct     = fn;
        mem_ready = 1'b1;
        #1;
        chk(tag, ev(0, 0, 0, 1, 1, 0, 1, 0, 0, 0, 1, 0, 0));
        cyc();
    endtask

    // Outputs in DECODE for an ordinary instruction (no strobes)
    localparam logic [18:0] DEC_QUIET = 19'h00000 | (19'd1 << 16) | (19'd1 << 10);

    initial begin
        rst       = 1'b1;
        opcode    = 6'h00;
        funct     = 6'h00;
        zero      = 1'b0;
        mem_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset", ev(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));

        rst = 1'b0;
        #1;
        chk("fetch_wait", ev(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0));
        cyc();
        chk("fetch_hold", ev(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0));

        // add: 0,1,2,4,0
        fetch("add_fetch", 6'h00, 6'h20);
        chk("add_decode", DEC_QUIET);
        cyc();
        chk("add_exec", ev(2, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        cyc();
        chk("add_wb", ev(4, 1, 0, 1, 0, 0, 0, 1, 1, 0, 0, 0, 0));
        cyc();

        // lw with three memory wait cycles
        fetch("lw_fetch", 6'h23, 6'h00);
        chk("lw_decode", DEC_QUIET);
        mem_ready = 1'b0;
        cyc();
        chk("lw_exec", ev(2, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        cyc();
        for (int i = 0; i < 3; i++) begin
            chk("lw_mem_wait", ev(3, 1, 1, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0));
            cyc();
        end
        mem_ready = 1'b1;
        #1;
        chk("lw_mem_done", ev(3, 1, 1, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0));
        cyc();
        chk("lw_wb", ev(4, 1, 1, 1, 0, 0, 0, 1, 0, 1, 0, 0, 0));
        cyc();

        // beq taken
        fetch("beq_fetch", 6'h04, 6'h00);
        chk("beq_decode", DEC_QUIET);
        zero = 1'b1;
        cyc();
        chk("beq_exec", ev(2, 3, 0, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0));
        cyc();

        // bne not taken
        fetch("bne_fetch", 6'h05, 6'h00);
        chk("bne_decode", DEC_QUIET);
        zero = 1'b0;
        cyc();
        chk("bne_exec", ev(2, 13, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0));
        cyc();

        // j
        fetch("j_fetch", 6'h02, 6'h00);
        chk("j_decode", ev(1, 0, 0, 1, 1, 2, 0, 0, 0, 0, 0, 0, 0));
        cyc();

        // illegal opcode 3F
        fetch("ill_fetch", 6'h3F, 6'h00);
        chk("ill_decode", ev(1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1));
        cyc();

        // ori: zero-extended immediate, writes rt
        fetch("ori_fetch", 6'h0D, 6'h00);
        chk("ori_decode", DEC_QUIET);
        cyc();
        opcode = 6'h3F; // IR fields changing after DECODE must not matter
        #1;
        chk("ori_exec", ev(2, 6, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        cyc();
        chk("ori_wb", ev(4, 6, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0));
        cyc();

        // jr
        fetch("jr_fetch", 6'h00, 6'h08);
        chk("jr_decode", DEC_QUIET);
        cyc();
        chk("jr_exec", ev(2, 12, 0, 1, 1, 3, 0, 0, 0, 0, 0, 0, 0));
        cyc();

        // sw interrupted by reset while waiting in MEM
        fetch("sw_fetch", 6'h2B, 6'h00);
        chk("sw_decode", DEC_QUIET);
        mem_ready = 1'b0;
        cyc();
        chk("sw_exec", ev(2, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        cyc();
        chk("sw_mem", ev(3, 1, 1, 1, 0, 0, 0, 0, 0, 0, 1, 1, 0));
        #2;
        rst = 1'b1;
        #1;
        chk("sw_async_rst", ev(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        cyc();
        chk("sw_rst_held", ev(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        rst       = 1'b0;
        mem_ready = 1'b1;
        opcode    = 6'h00;
        funct     = 6'h20;
        #1;
        chk("post_rst_fetch", ev(0, 0, 0, 1, 1, 0, 1, 0, 0, 0, 1, 0, 0));
        cyc();
        chk("post_rst_decode", DEC_QUIET);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
